y_rr_arbiter8: RTL and testbench
================================

Y_RR_ARBITER8 -- requirements
Module: y_rr_arbiter8

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, giving the data word width per requester.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset: clk, input, 1, rising-edge clock.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 req  input  8  request per requester i (bit i).
REQ-005 din  input  8*SIZE  requester data; slice i = din[i*SIZE +: SIZE].
REQ-006 out_ready  input  1  downstream consumer accepts out_data this cycle.
REQ-007 out_valid  output  1  out_data holds a granted word.
REQ-008 out_data  output  SIZE  din slice selected by sel.
REQ-009 sel  output  3  index of current grantee; drives the 8-to-1 mux select.
REQ-010 gnt  output  8  one-hot grant; all-zero when out_valid=0.
REQ-011 ack  output  8  one-hot transfer strobe to the grantee.
REQ-012 xfer_cnt  output  16  count of completed transfers.

Function
REQ-013 The state machine SHALL have two states: IDLE and BUSY.
REQ-014 The round-robin pointer ptr[2:0] SHALL hold the highest-priority index. Search order SHALL be ptr, ptr+1, ... ptr+7, mod 8.
REQ-015 In IDLE with req != 0 at edge N, the block SHALL register sel = first requester in search order and enter BUSY. out_valid SHALL be 1 from cycle N+1 (one-cycle latency).
REQ-016 In IDLE with req == 0, the block SHALL stay in IDLE with out_valid=0, gnt=0 and sel unchanged.
REQ-017 In BUSY:
- out_valid SHALL be 1.
- gnt SHALL be 1<<sel.
- out_data SHALL equal din slice sel, combinationally from din.
REQ-018 A transfer SHALL occur in any BUSY cycle with out_ready=1. In that cycle ack SHALL be gnt combinationally, otherwise ack SHALL be 0.
REQ-019 On a transfer:
- ptr SHALL become sel+1 mod 8 (7 wraps to 0).
- xfer_cnt SHALL increment, wrapping 65535->0.
REQ-020 On a transfer, the next grantee SHALL be chosen from req with bit sel masked, searching from the new ptr.
- If a requester is found, the block SHALL stay in BUSY with the new sel, with no idle bubble.
- Otherwise it SHALL enter IDLE.
REQ-021 In BUSY with out_ready=0, sel, gnt and out_valid SHALL hold, even if req[sel] deasserts (protocol violation; the grant is sticky).
REQ-022 Requesters SHALL hold din stable while req is high until acked. The block SHALL NOT capture data.
REQ-023 Requests from non-granted requesters arriving during BUSY SHALL NOT change sel until a transfer.

Reset
REQ-024 With rst_n=0 at a rising edge, the block SHALL:
- enter IDLE;
- set ptr=0, sel=0, xfer_cnt=0;
- make out_valid=0, gnt=0, ack=0 from that cycle.
REQ-025 Reset asserted during BUSY SHALL abandon the grant with no ack, and arbitration SHALL restart from ptr=0.
REQ-026 Reset SHALL NOT take effect without a clock edge.

Structure
REQ-027 State encodings (IDLE=0, BUSY=1), the requester count 8 and the counter width 16 SHALL be constants in the shared package.
REQ-028 The datapath SHALL be one instance of the existing yMux8to1 #(SIZE), fed by the din slices and sel. Only the controller logic is new RTL.
REQ-029 The round-robin search SHALL be a combinational function in the block, not a separate module.

Verification
REQ-030 The bench SHALL cover these five directed scenarios:
- Reset then req=8'b0000_0100, out_ready=1, din slice 2=32'h0000_002A: out_valid at the next cycle, sel=2, out_data=42, ack=8'b0000_0100 for one cycle, ptr=3, xfer_cnt=1, then IDLE.
- req=8'hFF held, out_ready=1 for 10 transfers: grant order 0,1,2,...,7,0,1 with no gaps after the first; xfer_cnt=10.
- Grant to 5, out_ready=0 for 4 cycles while req[5] drops and req[1] rises: sel stays 5, ack=0; when out_ready=1, one ack to 5, then sel=1.
- ptr=7 (after a grant to 6), req=8'b1000_0001: grant 7 then 0 (wrap-around).
- rst_n=0 mid-BUSY with sel=4: next cycle out_valid=0, gnt=0, xfer_cnt=0; with req=8'hFF after reset, the first grant is 0.

Source files
------------

// File: rtl/y_rr_arbiter8_pkg.sv
// ---------------------------------------------------------------------------
// y_rr_arbiter8_pkg
//
// Shared constants and types for the eight-way round-robin arbiter.
//
// Contents:
//   NUM_REQ      number of requesters the arbiter serves
//   IDX_W        width of a requester index (sel, round-robin pointer)
//   CNT_W        width of the completed-transfer counter
//   arb_state_t  controller states (IDLE = 0, BUSY = 1)
//   pick_t       result of a round-robin search: found flag plus index
// ---------------------------------------------------------------------------
package y_rr_arbiter8_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

endpackage

// File: rtl/y_rr_arbiter8_mux.sv
// ---------------------------------------------------------------------------
// yMux8to1
//
// Plain eight-input word multiplexer. The arbiter uses it as its whole
// datapath: the grantee's word is steered straight from the requester
// inputs to the output, nothing is stored.
//
// Ports:
//   in0..in7  input  SIZE  candidate words
//   sel       input  3     index of the word to pass through
//   y         output SIZE  selected word
// ---------------------------------------------------------------------------
module yMux8to1 #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] in0,
    input  logic [SIZE-1:0] in1,
    input  logic [SIZE-1:0] in2,
    input  logic [SIZE-1:0] in3,
    input  logic [SIZE-1:0] in4,
    input  logic [SIZE-1:0] in5,
    input  logic [SIZE-1:0] in6,
    input  logic [SIZE-1:0] in7,
    input  logic [2:0]      sel,
    output logic [SIZE-1:0] y
);

    // Straight decode of the select; every case is covered so no latch
    // can form.
    always_comb begin
        case (sel)
            3'd0:    y = in0;
            3'd1:    y = in1;
            3'd2:    y = in2;
            3'd3:    y = in3;
            3'd4:    y = in4;
            3'd5:    y = in5;
            3'd6:    y = in6;
            default: y = in7;
        endcase
    end

endmodule

// File: rtl/y_rr_arbiter8.sv
// ---------------------------------------------------------------------------
// y_rr_arbiter8
//
// Eight-requester round-robin arbiter with a valid/ready output port.
// One requester at a time is granted. Its data word is routed through an
// 8-to-1 mux to out_data until the consumer accepts it. After an accepted
// transfer, the priority pointer moves to one past the grantee. The next
// grantee is then picked in the same cycle, so back-to-back requesters are
// served with no idle bubble.
//
// Ports:
//   clk        input  1          rising-edge clock
//   rst_n      input  1          synchronous active-low reset
//   req        input  8          request, one bit per requester
//   din        input  8*SIZE     requester words, slice i = din[i*SIZE +: SIZE]
//   out_ready  input  1          consumer accepts out_data this cycle
//   out_valid  output 1          out_data holds the granted word
//   out_data   output SIZE       word of the current grantee
//   sel        output 3          index of the current grantee
//   gnt        output 8          one-hot grant, zero when out_valid is low
//   ack        output 8          one-hot strobe to the grantee on a transfer
//   xfer_cnt   output 16         number of completed transfers (wraps)
// ---------------------------------------------------------------------------
module y_rr_arbiter8
    import y_rr_arbiter8_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*SIZE-1:0] din,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [SIZE-1:0]         out_data,
    output logic [IDX_W-1:0]        sel,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      ack,
    output logic [CNT_W-1:0]        xfer_cnt
);

    arb_state_t          state;
    logic [IDX_W-1:0]    ptr;
    logic                xfer;
    logic [IDX_W-1:0]    next_ptr;
    logic [NUM_REQ-1:0]  masked_req;
    pick_t               first_pick;
    pick_t               next_pick;

    // Round-robin search. The request vector is rotated right by the
    // starting index, so the highest-priority requester lands in bit 0.
    // The lowest set bit of the rotated vector is then the winner. Scanning
    // from the top down and overwriting leaves the lowest set bit. Adding
    // the start back in IDX_W-bit arithmetic undoes the rotation and wraps
    // 7 -> 0 for free.
    function automatic pick_t rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [IDX_W-1:0]   from
    );
        logic [NUM_REQ-1:0] rot;
        pick_t              p;
        rot     = NUM_REQ'({r, r} >> from);
        p.found = |rot;
        p.idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                p.idx = from + IDX_W'(k);
            end
        end
        return p;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return NUM_REQ'(1) << i;
    endfunction

    // Next-grant candidates. first_pick is used when leaving IDLE and
    // searches from the stored pointer. next_pick is used on a transfer.
    // It searches from one past the grantee with the grantee's own request
    // masked out. The grantee still has req high in the cycle it is acked,
    // and must not be re-granted on that stale bit.
    always_comb begin
        xfer       = (state == BUSY) && out_ready;
        next_ptr   = sel + 1'b1;
        masked_req = req & ~onehot(sel);
        first_pick = rr_pick(req, ptr);
        next_pick  = rr_pick(masked_req, next_ptr);
    end

    // Controller. out_valid and gnt are registered alongside the state, so
    // they change only on clock edges. The grant stays sticky while the
    // consumer stalls, even if the grantee drops its request or others
    // arrive. Reset has priority over everything, including a transfer in
    // progress: that grant is simply abandoned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            xfer_cnt  <= '0;
            out_valid <= 1'b0;
            gnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (first_pick.found) begin
                        state     <= BUSY;
                        sel       <= first_pick.idx;
                        out_valid <= 1'b1;
                        gnt       <= onehot(first_pick.idx);
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        ptr      <= next_ptr;
                        xfer_cnt <= xfer_cnt + 1'b1;
                        if (next_pick.found) begin
                            sel <= next_pick.idx;
                            gnt <= onehot(next_pick.idx);
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            gnt       <= '0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    gnt       <= '0;
                end
            endcase
        end
    end

    // The transfer strobe is purely combinational. gnt is already zero
    // outside BUSY, so masking it with out_ready is enough.
    always_comb begin
        ack = gnt & {NUM_REQ{out_ready}};
    end

    yMux8to1 #(
        .SIZE (SIZE)
    ) u_mux (
        .in0 (din[0*SIZE +: SIZE]),
        .in1 (din[1*SIZE +: SIZE]),
        .in2 (din[2*SIZE +: SIZE]),
        .in3 (din[3*SIZE +: SIZE]),
        .in4 (din[4*SIZE +: SIZE]),
        .in5 (din[5*SIZE +: SIZE]),
        .in6 (din[6*SIZE +: SIZE]),
        .in7 (din[7*SIZE +: SIZE]),
        .sel (sel),
        .y   (out_data)
    );

endmodule

// File: tb/tb_y_rr_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_y_rr_arbiter8
//
// Bench for y_rr_arbiter8. A behavioural model predicts the outputs of
// every cycle and every accepted transfer, and pushes them into queues.
// A separate monitor pops the queues and compares against the DUT.
// Directed scenarios also check grant order and counts against constants.
// ---------------------------------------------------------------------------
module tb_y_rr_arbiter8;

    localparam int SIZE = 32;
    localparam int N    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*SIZE-1:0] din = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [SIZE-1:0]   out_data;
    logic [2:0]        sel;
    logic [N-1:0]      gnt;
    logic [N-1:0]      ack;
    logic [15:0]       xfer_cnt;

    y_rr_arbiter8 #(
        .SIZE (SIZE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .gnt       (gnt),
        .ack       (ack),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              valid;
        logic [2:0]      sel;
        logic [N-1:0]    gnt;
        logic [N-1:0]    ack;
        logic [15:0]     cnt;
        logic [SIZE-1:0] data;
    } cyc_t;

    typedef struct {
        int              idx;
        logic [SIZE-1:0] data;
    } xfer_t;

    cyc_t            cyc_q[$];
    xfer_t           xfer_q[$];
    int              obs_order[$];
    logic [SIZE-1:0] obs_data[$];

    int total = 0;
    int bad   = 0;

    // Reference model state: whether a grant is outstanding, who holds it,
    // where the next search starts and how many transfers have completed.
    bit m_known = 1'b0;
    bit m_busy  = 1'b0;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    // First requester found walking ptr, ptr+1, ... modulo 8; -1 if none.
    function automatic int rr_first(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got,
                               input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic checkOrder(input string name, input int want[$]);
        checkOutput({name, "_len"}, 64'(obs_order.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < obs_order.size(); i++) begin
            checkOutput({name, "_idx"}, 64'(obs_order[i]), 64'(want[i]));
        end
    endtask

    // Drive one cycle of inputs and record what the model says the DUT
    // must show during this cycle. Then step the model across the coming
    // clock edge.
    task automatic applyStimulus(input logic rst_v, input logic [N-1:0] req_v,
                                 input logic rdy_v, input logic [N*SIZE-1:0] din_v);
        cyc_t  e;
        xfer_t x;
        int    p;
        @(posedge clk);
        #1;
        rst_n     = rst_v;
        req       = req_v;
        out_ready = rdy_v;
        din       = din_v;
        if (m_known) begin
            e.valid = m_busy;
            e.sel   = 3'(m_sel);
            e.gnt   = m_busy ? (N'(1) << m_sel) : '0;
            e.ack   = (m_busy && rdy_v) ? e.gnt : '0;
            e.cnt   = 16'(m_cnt);
            e.data  = din_v[m_sel*SIZE +: SIZE];
            cyc_q.push_back(e);
        end
        if (!rst_v) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_ptr   = 0;
            m_sel   = 0;
            m_cnt   = 0;
        end else if (m_known) begin
            if (!m_busy) begin
                p = rr_first(req_v, m_ptr);
                if (p >= 0) begin
                    m_sel  = p;
                    m_busy = 1'b1;
                end
            end else if (rdy_v) begin
                x.idx  = m_sel;
                x.data = din_v[m_sel*SIZE +: SIZE];
                xfer_q.push_back(x);
                m_ptr = (m_sel + 1) % N;
                m_cnt = (m_cnt + 1) % 65536;
                p = rr_first(req_v & ~(N'(1) << m_sel), m_ptr);
                if (p >= 0) m_sel = p;
                else        m_busy = 1'b0;
            end
        end
    endtask

    function automatic logic [N*SIZE-1:0] rand_din();
        logic [N*SIZE-1:0] d;
        for (int i = 0; i < N; i++) d[i*SIZE +: SIZE] = $urandom;
        return d;
    endfunction

    // Monitor: every negedge, compare the cycle's predicted status. When
    // the DUT presents a word that is being accepted, pop the predicted
    // transfer and compare that too, logging the order for directed checks.
    initial begin
        cyc_t  e;
        xfer_t x;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                checkOutput("out_valid", 64'(out_valid), 64'(e.valid));
                checkOutput("sel",       64'(sel),       64'(e.sel));
                checkOutput("gnt",       64'(gnt),       64'(e.gnt));
                checkOutput("ack",       64'(ack),       64'(e.ack));
                checkOutput("xfer_cnt",  64'(xfer_cnt),  64'(e.cnt));
                if (e.valid) checkOutput("out_data", 64'(out_data), 64'(e.data));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (xfer_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL xfer_unexpected got=sel%0d want=none", sel);
                end else begin
                    x = xfer_q.pop_front();
                    checkOutput("xfer_sel",  64'(sel),      64'(x.idx));
                    checkOutput("xfer_data", 64'(out_data), 64'(x.data));
                end
                obs_order.push_back(int'(sel));
                obs_data.push_back(out_data);
            end
        end
    end

    initial begin
        logic [N*SIZE-1:0] d;
        int                want[$];
        logic              r;

        // Scenario 1: single request from requester 2.
        applyStimulus(1'b0, '0, 1'b0, '0);
        d = '0;
        d[2*SIZE +: SIZE] = 32'h0000_002A;
        obs_order.delete();
        obs_data.delete();
        applyStimulus(1'b1, 8'b0000_0100, 1'b1, d);
        applyStimulus(1'b1, 8'b0000_0100, 1'b1, d);
        applyStimulus(1'b1, 8'b0000_0000, 1'b1, d);
        @(negedge clk);
        #1;
        want = '{2};
        checkOrder("s1_order", want);
        if (obs_data.size() > 0) checkOutput("s1_data", 64'(obs_data[0]), 64'd42);
        checkOutput("s1_xfer_cnt", 64'(xfer_cnt), 64'd1);
        checkOutput("s1_idle", 64'(out_valid), 64'd0);

        // Scenario 2: everyone requesting, ten back-to-back transfers.
        applyStimulus(1'b0, '0, 1'b0, '0);
        obs_order.delete();
        repeat (11) applyStimulus(1'b1, 8'hFF, 1'b1, rand_din());
        applyStimulus(1'b1, 8'hFF, 1'b0, rand_din());
        @(negedge clk);
        #1;
        want = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        checkOrder("s2_order", want);
        checkOutput("s2_xfer_cnt", 64'(xfer_cnt), 64'd10);

        // Scenario 3: stalled grant to 5 stays sticky while requests change.
        applyStimulus(1'b0, '0, 1'b0, '0);
        obs_order.delete();
        applyStimulus(1'b1, 8'h20, 1'b0, rand_din());
        repeat (4) applyStimulus(1'b1, 8'h02, 1'b0, rand_din());
        applyStimulus(1'b1, 8'h02, 1'b1, rand_din());
        applyStimulus(1'b1, 8'h02, 1'b1, rand_din());
        applyStimulus(1'b1, 8'h00, 1'b1, rand_din());
        @(negedge clk);
        #1;
        want = '{5, 1};
        checkOrder("s3_order", want);

        // Scenario 4: pointer wrap 6 -> 7 -> 0.
        applyStimulus(1'b0, '0, 1'b0, '0);
        obs_order.delete();
        applyStimulus(1'b1, 8'h40, 1'b1, rand_din());
        applyStimulus(1'b1, 8'h81, 1'b1, rand_din());
        applyStimulus(1'b1, 8'h81, 1'b1, rand_din());
        applyStimulus(1'b1, 8'h01, 1'b1, rand_din());
        applyStimulus(1'b1, 8'h00, 1'b1, rand_din());
        @(negedge clk);
        #1;
        want = '{6, 7, 0};
        checkOrder("s4_order", want);

        // Scenario 5: reset while granted to 4 abandons the grant.
        applyStimulus(1'b0, '0, 1'b0, '0);
        obs_order.delete();
        applyStimulus(1'b1, 8'h08, 1'b1, rand_din());
        applyStimulus(1'b1, 8'h10, 1'b1, rand_din());
        applyStimulus(1'b1, 8'h10, 1'b0, rand_din());
        applyStimulus(1'b0, 8'h10, 1'b0, rand_din());
        applyStimulus(1'b1, 8'hFF, 1'b1, rand_din());
        @(negedge clk);
        #1;
        checkOutput("s5_valid_after_rst", 64'(out_valid), 64'd0);
        checkOutput("s5_gnt_after_rst",   64'(gnt),       64'd0);
        checkOutput("s5_cnt_after_rst",   64'(xfer_cnt),  64'd0);
        applyStimulus(1'b1, 8'hFF, 1'b1, rand_din());
        applyStimulus(1'b1, 8'h00, 1'b0, rand_din());
        @(negedge clk);
        #1;
        want = '{3, 0};
        checkOrder("s5_order", want);

        // Random traffic with sparse requests, random back-pressure and
        // occasional resets.
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 60) != 0);
            applyStimulus(r, N'($urandom & $urandom),
                          r && ($urandom_range(0, 3) != 0), rand_din());
        end
        applyStimulus(1'b1, '0, 1'b0, rand_din());
        repeat (2) @(negedge clk);
        #1;
        checkOutput("cyc_q_drained",  64'(cyc_q.size()),  64'd0);
        checkOutput("xfer_q_drained", 64'(xfer_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
